// File: rtl/ir_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : ir_cmd_controller
// Purpose  : Takes decoded NEC frames from IR_RECEIVE and validates them.
//            Maps key bytes to state_control commands and suppresses
//            auto-repeat. Issues commands to the UART JSON sender through
//            a valid/done handshake with timeout recovery.
// Revision : 1.0 - initial release
// ============================================================================
module ir_cmd_controller #(
   parameter logic [15:0] CUSTOM_CODE    = 16'h6B86,
   parameter bit          CHECK_CUSTOM   = 1'b1,
   parameter logic [7:0]  KEY_STOP       = 8'h16,
   parameter logic [7:0]  KEY_FWD        = 8'h02,
   parameter logic [7:0]  KEY_BACK       = 8'h08,
   parameter logic [7:0]  KEY_LEFT       = 8'h04,
   parameter logic [7:0]  KEY_RIGHT      = 8'h06,
   parameter logic [7:0]  KEY_TOGGLE     = 8'h12,
   parameter int unsigned HOLDOFF_CYCLES = 12_500_000,
   parameter int unsigned DONE_TIMEOUT   = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir_data,
   input  logic        data_ready,
   input  logic        send_done,
   output logic [2:0]  state_control,
   output logic        cmd_valid,
   output logic        toggle,
   output logic [7:0]  ir_button,
   output logic        busy,
   output logic [7:0]  err_count,
   output logic        timeout_flag
);

   // Counter widths; a single bit minimum keeps degenerate settings legal.
   localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam int TO_W   = (DONE_TIMEOUT > 1)   ? $clog2(DONE_TIMEOUT)   : 1;

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(DONE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_CHECK     = 2'd1,
      S_ISSUE     = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t            state;
   logic              dr_q;
   logic              dr_prev;
   logic              ev;
   logic [31:0]       frame_q;
   logic [7:0]        key;
   logic [7:0]        last_key;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              frame_ok;
   logic              suppress;
   logic              key_mapped;
   logic [2:0]        key_code;

   // Register data_ready and keep its previous value so either a pulse or a
   // held level produces exactly one event on its rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dr_q    <= 1'b0;
         dr_prev <= 1'b0;
      end else begin
         dr_q    <= data_ready;
         dr_prev <= dr_q;
      end
   end

   assign ev  = dr_q & ~dr_prev;
   assign key = frame_q[23:16];

   // The inverted-key byte must match, and the custom code too when enabled.
   assign frame_ok = (frame_q[31:24] == ~key) &&
                     (!CHECK_CUSTOM || (frame_q[15:0] == CUSTOM_CODE));

   // A repeat of the last accepted key inside the hold-off window is dropped.
   assign suppress = (key == last_key) && (hold_cnt != '0);

   // Translate the key byte into a movement command code.
   always_comb begin
      key_mapped = 1'b1;
      key_code   = 3'd0;
      if (key == KEY_STOP)       key_code = 3'd0;
      else if (key == KEY_FWD)   key_code = 3'd1;
      else if (key == KEY_BACK)  key_code = 3'd2;
      else if (key == KEY_LEFT)  key_code = 3'd3;
      else if (key == KEY_RIGHT) key_code = 3'd4;
      else                       key_mapped = 1'b0;
   end

   // Command sequencer with its hold-off and handshake timeout counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         frame_q       <= '0;
         last_key      <= '0;
         hold_cnt      <= '0;
         to_cnt        <= '0;
         state_control <= 3'd0;
         cmd_valid     <= 1'b0;
         toggle        <= 1'b0;
         ir_button     <= 8'd0;
         busy          <= 1'b0;
         err_count     <= 8'd0;
         timeout_flag  <= 1'b0;
      end else begin
         // Hold-off window drains every cycle; an accepted key reloads it below.
         if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);

         case (state)
            S_IDLE: begin
               if (ev) begin
                  frame_q <= ir_data;
                  state   <= S_CHECK;
                  busy    <= 1'b1;
               end
            end

            S_CHECK: begin
               if (!frame_ok) begin
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  ir_button <= key;
                  if (suppress) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     last_key <= key;
                     hold_cnt <= HOLD_LOAD;
                     if (key == KEY_TOGGLE) begin
                        toggle <= ~toggle;
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                     end else if (key_mapped) begin
                        state_control <= key_code;
                        state         <= S_ISSUE;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
            end

            S_ISSUE: begin
               cmd_valid <= 1'b1;
               to_cnt    <= '0;
               state     <= S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
               // send_done wins over a coincident timeout.
               if (send_done) begin
                  cmd_valid <= 1'b0;
                  state     <= S_IDLE;
                  busy      <= 1'b0;
               end else if (to_cnt == TO_LAST) begin
                  cmd_valid    <= 1'b0;
                  timeout_flag <= 1'b1;
                  state        <= S_IDLE;
                  busy         <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            default: begin
               cmd_valid <= 1'b0;
               state     <= S_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_cmd_controller
// Purpose  : Randomized scoreboard bench for ir_cmd_controller. A reference
//            model predicts each issued command. A monitor matches cmd_valid
//            against the predictions and checks how each command is released.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_controller;

   localparam int HOLD = 100;
   localparam int TOUT = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ir_data;
   logic        data_ready;
   logic        send_done;
   logic [2:0]  state_control;
   logic        cmd_valid;
   logic        toggle;
   logic [7:0]  ir_button;
   logic        busy;
   logic [7:0]  err_count;
   logic        timeout_flag;

   ir_cmd_controller #(
      .HOLDOFF_CYCLES (HOLD),
      .DONE_TIMEOUT   (TOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ir_data       (ir_data),
      .data_ready    (data_ready),
      .send_done     (send_done),
      .state_control (state_control),
      .cmd_valid     (cmd_valid),
      .toggle        (toggle),
      .ir_button     (ir_button),
      .busy          (busy),
      .err_count     (err_count),
      .timeout_flag  (timeout_flag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run = 0;
   int fails     = 0;

   typedef struct {
      logic [2:0] code;
      logic [7:0] key;
      int         rise;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state
   int         m_err;
   logic       m_toggle;
   logic [7:0] m_button;
   logic [2:0] m_code;
   logic       m_timeout;
   bit         m_have_last;
   logic [7:0] m_last_key;
   int         m_last_t;

   // Responder controls
   bit auto_done  = 1'b1;
   int done_delay = -1;
   int done_cyc   = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_err = 0; m_toggle = 1'b0; m_button = 8'd0; m_code = 3'd0;
      m_timeout = 1'b0; m_have_last = 1'b0; m_last_key = 8'd0; m_last_t = 0;
   endtask

   // Predict the outcome of a frame whose data_ready pulse is driven at cycle t.
   task automatic model_frame(input logic [31:0] f, input int t);
      logic [7:0] k;
      exp_t       e;
      int         code;
      k = f[23:16];
      if (f[31:24] != ~k || f[15:0] != 16'h6B86) begin
         if (m_err < 255) m_err++;
         return;
      end
      m_button = k;
      if (m_have_last && k == m_last_key && (t - m_last_t) < HOLD) return;
      m_have_last = 1'b1;
      m_last_key  = k;
      m_last_t    = t;
      case (k)
         8'h16:   code = 0;
         8'h02:   code = 1;
         8'h08:   code = 2;
         8'h04:   code = 3;
         8'h06:   code = 4;
         default: code = -1;
      endcase
      if (k == 8'h12) m_toggle = ~m_toggle;
      else if (code >= 0) begin
         m_code = code[2:0];
         e.code = code[2:0];
         e.key  = k;
         e.rise = t + 4;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((busy || cmd_valid) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (busy || cmd_valid) check("idle_wait", {30'd0, busy, cmd_valid}, 32'd0);
   endtask

   task automatic send_frame(input logic [31:0] f, output int t);
      wait_idle(400);
      ir_data    = f;
      data_ready = 1'b1;
      t          = cyc;
      model_frame(f, t);
      @(negedge clk);
      data_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_state();
      wait_idle(400);
      check("busy", busy, 0);
      check("state_control", state_control, m_code);
      check("ir_button", ir_button, m_button);
      check("err_count", err_count, m_err);
      check("toggle", toggle, m_toggle);
      check("timeout_flag", timeout_flag, m_timeout);
   endtask

   task automatic check_reset_vals();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_state_control", state_control, 0);
      check("rst_toggle", toggle, 0);
      check("rst_err_count", err_count, 0);
      check("rst_timeout_flag", timeout_flag, 0);
      check("rst_busy", busy, 0);
      check("rst_ir_button", ir_button, 0);
   endtask

   // Wait until cycle target (or return at once if already past it).
   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Responder: answers cmd_valid with a send_done pulse after a delay.
   initial begin
      int d;
      send_done = 1'b0;
      forever begin
         @(negedge clk);
         if (cmd_valid && auto_done && !rst) begin
            d = (done_delay >= 0) ? done_delay : int'($urandom_range(0, 30));
            repeat (d) @(negedge clk);
            if (cmd_valid && !rst) begin
               send_done = 1'b1;
               done_cyc  = cyc;
               @(negedge clk);
               send_done = 1'b0;
            end
         end
      end
   end

   // Monitor: match each cmd_valid assertion against the scoreboard.
   initial begin
      logic       prev_v;
      int         rise_cyc;
      logic [2:0] sc_at_rise;
      exp_t       e;
      prev_v = 1'b0; rise_cyc = 0; sc_at_rise = 3'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
            continue;
         end
         if (cmd_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
               check("unexpected_cmd", cmd_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("cmd_code", state_control, e.code);
               check("cmd_key", ir_button, e.key);
               check("cmd_rise_cycle", cyc, e.rise);
            end
            rise_cyc   = cyc;
            sc_at_rise = state_control;
         end else if (cmd_valid) begin
            check("sc_stable", state_control, sc_at_rise);
         end else if (prev_v) begin
            if (done_cyc >= rise_cyc) begin
               check("done_release", cyc, done_cyc + 1);
            end else begin
               check("timeout_len", cyc - rise_cyc, TOUT);
               check("timeout_set", timeout_flag, 1);
            end
         end
         prev_v = cmd_valid;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          t0;
      int          t1;
      logic [7:0]  keys [7];
      logic [7:0]  k;
      logic [7:0]  prev_k;
      logic [7:0]  bitm;
      logic [31:0] f;
      keys[0] = 8'h16; keys[1] = 8'h02; keys[2] = 8'h08; keys[3] = 8'h04;
      keys[4] = 8'h06; keys[5] = 8'h12; keys[6] = 8'h55;

      rst = 1'b1; ir_data = 32'd0; data_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals();
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: basic FWD command with send_done 10 cycles after cmd_valid
      done_delay = 10;
      send_frame(32'hFD02_6B86, t0);
      check_state();
      done_delay = -1;

      // 2: invalid frames and err_count saturation
      send_frame(32'hFC02_6B86, t0);
      send_frame(32'hFD02_1234, t0);
      check_state();
      for (int i = 0; i < 256; i++) begin
         f = 32'hFD02_6B86;
         if (i[0]) f[15:0] = 16'h1234; else f[31:24] = 8'h7D;
         send_frame(f, t0);
      end
      check_state();

      // 3: hold-off suppression and different-key acceptance
      send_frame(32'hFD02_6B86, t0);
      wait_until(t0 + 50);
      send_frame(32'hFD02_6B86, t1);
      check_state();
      wait_until(t0 + 150);
      done_delay = 0;
      send_frame(32'hFD02_6B86, t1);
      wait_until(t1 + 10);
      send_frame(32'hF708_6B86, t1);
      check_state();
      done_delay = -1;

      // 4: toggle key twice, no command
      send_frame(32'hED12_6B86, t0);
      check_state();
      wait_until(t0 + 150);
      send_frame(32'hED12_6B86, t1);
      check_state();

      // 5: RIGHT without send_done times out; LEFT still accepted
      auto_done = 1'b0;
      send_frame(32'hF906_6B86, t0);
      m_timeout = 1'b1;
      check_state();
      auto_done = 1'b1;
      send_frame(32'hFB04_6B86, t0);
      check_state();

      // 6: reset during WAIT_DONE, then FWD accepted right after
      send_frame(32'hED12_6B86, t0);
      check_state();
      auto_done = 1'b0;
      send_frame(32'hFD02_6B86, t0);
      repeat (5) @(negedge clk);
      check("pre_rst_valid", cmd_valid, 1);
      #2 rst = 1'b1;
      #1 check_reset_vals();
      model_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      auto_done = 1'b1;
      send_frame(32'hFD02_6B86, t1);
      check_state();

      // Randomized frames with random gaps, keys and corruption
      prev_k = 8'h02;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 4) k = prev_k;
         else k = keys[$urandom_range(0, 6)];
         prev_k = k;
         f = {~k, k, 16'h6B86};
         case ($urandom_range(0, 9))
            0: begin
               bitm = 8'h01 << $urandom_range(0, 7);
               f[31:24] = f[31:24] ^ bitm;
            end
            1: f[15:0] = f[15:0] ^ 16'h0100;
            default: ;
         endcase
         repeat ($urandom_range(0, 110)) @(negedge clk);
         send_frame(f, t0);
         check_state();
      end

      wait_idle(400);
      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
`default_nettype wire
